// File: rtl/conv_ctrl_fsm_gen_pkg.sv
// Shared types and helpers for the conv-layer sequencer.
package conv_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_K,
    LOAD_I,
    I_SHIFT,
    COMPUTE,
    OUT_WAIT,
    DONE
  } fsm_state_t;

  // Output mux select value meaning "no way selected"; sliced to the port width.
  localparam logic [31:0] ODS_SEL_IDLE = '1;

  // Number of channel groups, counting a partial last group.
  function automatic int num_groups(input int total, input int par);
    return (total + par - 1) / par;
  endfunction

  // Counter width for a given extent, never below one bit.
  function automatic int cnt_width(input int extent);
    return (extent <= 1) ? 1 : $clog2(extent);
  endfunction

endpackage

// File: rtl/conv_ctrl_fsm_gen_if.sv
// Host stream and result handshake bundle of the conv-layer sequencer.
interface conv_ctrl_fsm_gen_if;

  logic        con_valid;
  logic        con_ready;
  logic        out_ready;
  logic        output_valid;
  logic [31:0] output_x;
  logic [31:0] output_y;
  logic [31:0] output_ch;

  // The sequencer consumes host beats and presents results.
  modport master (
    input  con_valid,
    input  out_ready,
    output con_ready,
    output output_valid,
    output output_x,
    output output_y,
    output output_ch
  );

  // The host / downstream side of the same bundle.
  modport slave (
    output con_valid,
    output out_ready,
    input  con_ready,
    input  output_valid,
    input  output_x,
    input  output_y,
    input  output_ch
  );

endinterface

// File: rtl/conv_ctrl_fsm_gen_loop_nest.sv
// x / y / channel-group loop nest; x is innermost, group outermost.
module loop_nest_counter
  import conv_ctrl_pkg::*;
#(
  parameter int X_EXT = 2,
  parameter int Y_EXT = 2,
  parameter int G_EXT = 1
) (
  input  logic                        clk,
  input  logic                        rst_in,
  input  logic                        clear,
  input  logic                        step,
  output logic [cnt_width(X_EXT)-1:0] x,
  output logic [cnt_width(Y_EXT)-1:0] y,
  output logic [cnt_width(G_EXT)-1:0] group,
  output logic                        last_x,
  output logic                        last_y,
  output logic                        last_group,
  output logic                        last_overall
);

  localparam int XW = cnt_width(X_EXT);
  localparam int YW = cnt_width(Y_EXT);
  localparam int GW = cnt_width(G_EXT);

  assign last_x       = (x == XW'(X_EXT - 1));
  assign last_y       = (y == YW'(Y_EXT - 1));
  assign last_group   = (group == GW'(G_EXT - 1));
  assign last_overall = last_x && last_y && last_group;

  // Advance the nest by one pixel per step, carrying x -> y -> group.
  always_ff @(posedge clk) begin
    if (rst_in || clear) begin
      x     <= '0;
      y     <= '0;
      group <= '0;
    end else if (step) begin
      if (!last_x) begin
        x <= x + 1'b1;
      end else begin
        x <= '0;
        if (!last_y) begin
          y <= y + 1'b1;
        end else begin
          y <= '0;
          if (!last_group) begin
            group <= group + 1'b1;
          end else begin
            group <= '0;
          end
        end
      end
    end
  end

endmodule

// File: rtl/conv_ctrl_fsm_gen.sv
// Conv-layer sequencer: loads kernel groups and input rows into the PE
// array, runs the compute phases and hands results downstream, looping
// over channel-group / y / x with full valid/ready on every beat.
module conv_ctrl_fsm_gen
  import conv_ctrl_pkg::*;
#(
  parameter int FEATURE_MAP_WIDTH  = 1024,
  parameter int FEATURE_MAP_HEIGHT = 1024,
  parameter int OUTPUT_NB_CHANNELS = 64,
  parameter int CH_OUT_PAR         = 6,
  parameter int K_BEATS            = 12,
  parameter int I_BEATS            = 4,
  parameter int PRELOAD_ROWS       = 3,
  parameter int COMPUTE_CYCLES     = 6,
  parameter int ODS_WAYS           = 3
) (
  input  logic                                 clk,
  input  logic                                 rst_in,
  input  logic                                 start,
  output logic                                 running,
  output logic                                 done,
  conv_ctrl_fsm_gen_if.master                  bus,
  output logic [K_BEATS-1:0]                   ctrl_kds_le_select,
  output logic [cnt_width(CH_OUT_PAR)-1:0]     ctrl_kds_ch_select,
  output logic [cnt_width(I_BEATS)-1:0]        ctrl_idss_le_select,
  output logic                                 ctrl_idss_shift,
  output logic                                 ctrl_ods_shift,
  output logic [$clog2(ODS_WAYS+1)-1:0]        ctrl_ods_sel_out,
  output logic                                 driving_cons
);

  localparam int NUM_GROUPS = num_groups(OUTPUT_NB_CHANNELS, CH_OUT_PAR);
  localparam int CH_REM     = OUTPUT_NB_CHANNELS % CH_OUT_PAR;
  localparam int LAST_CHS   = (CH_REM == 0) ? CH_OUT_PAR : CH_REM;
  localparam int KBW        = cnt_width(K_BEATS);
  localparam int KCW        = cnt_width(CH_OUT_PAR);
  localparam int IBW        = cnt_width(I_BEATS);
  localparam int IRW        = cnt_width(PRELOAD_ROWS);
  localparam int PHW        = cnt_width(COMPUTE_CYCLES);
  localparam int XW         = cnt_width(FEATURE_MAP_WIDTH);
  localparam int YW         = cnt_width(FEATURE_MAP_HEIGHT);
  localparam int GW         = cnt_width(NUM_GROUPS);
  localparam int SELW       = $clog2(ODS_WAYS + 1);

  localparam logic [K_BEATS-1:0] KSEL_ONE      = K_BEATS'(1);
  localparam logic [KCW-1:0]     KCH_LAST_FULL = KCW'(CH_OUT_PAR - 1);
  localparam logic [KCW-1:0]     KCH_LAST_PART = KCW'(LAST_CHS - 1);
  localparam logic [KBW-1:0]     KBEAT_LAST    = KBW'(K_BEATS - 1);
  localparam logic [IBW-1:0]     IBEAT_LAST    = IBW'(I_BEATS - 1);
  localparam logic [IRW-1:0]     IROW_LAST     = IRW'(PRELOAD_ROWS - 1);
  localparam logic [PHW-1:0]     PHASE_LAST    = PHW'(COMPUTE_CYCLES - 1);

  fsm_state_t state, state_n;

  logic [KBW-1:0] kbeat, kbeat_n;
  logic [KCW-1:0] kch, kch_n;
  logic [IBW-1:0] ibeat, ibeat_n;
  logic [IRW-1:0] irow, irow_n;
  logic [PHW-1:0] phase, phase_n;

  logic [XW-1:0]  x_cnt;
  logic [YW-1:0]  y_cnt;
  logic [GW-1:0]  group_cnt;
  logic           last_x, last_y, last_group, last_overall;

  logic           nest_clear;
  logic           nest_step;
  logic           load_out;
  logic           beat;
  logic           phase_adv;
  logic [KCW-1:0] kch_last;

  // Only the final group can be partial.
  assign kch_last = last_group ? KCH_LAST_PART : KCH_LAST_FULL;
  assign running  = (state != IDLE);

  loop_nest_counter #(
    .X_EXT (FEATURE_MAP_WIDTH),
    .Y_EXT (FEATURE_MAP_HEIGHT),
    .G_EXT (NUM_GROUPS)
  ) u_nest (
    .clk          (clk),
    .rst_in       (rst_in),
    .clear        (nest_clear),
    .step         (nest_step),
    .x            (x_cnt),
    .y            (y_cnt),
    .group        (group_cnt),
    .last_x       (last_x),
    .last_y       (last_y),
    .last_group   (last_group),
    .last_overall (last_overall)
  );

  // State and per-phase beat counters.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state <= IDLE;
      kbeat <= '0;
      kch   <= '0;
      ibeat <= '0;
      irow  <= '0;
      phase <= '0;
    end else begin
      state <= state_n;
      kbeat <= kbeat_n;
      kch   <= kch_n;
      ibeat <= ibeat_n;
      irow  <= irow_n;
      phase <= phase_n;
    end
  end

  // Next state, counter updates and datapath controls; selects hold on a stall.
  always_comb begin
    state_n             = state;
    kbeat_n             = kbeat;
    kch_n               = kch;
    ibeat_n             = ibeat;
    irow_n              = irow;
    phase_n             = phase;
    nest_clear          = 1'b0;
    nest_step           = 1'b0;
    load_out            = 1'b0;
    beat                = 1'b0;
    phase_adv           = 1'b0;
    done                = 1'b0;
    bus.con_ready       = 1'b0;
    ctrl_kds_le_select  = '0;
    ctrl_kds_ch_select  = '0;
    ctrl_idss_le_select = '0;
    ctrl_idss_shift     = 1'b0;
    ctrl_ods_shift      = 1'b0;
    ctrl_ods_sel_out    = ODS_SEL_IDLE[SELW-1:0];
    driving_cons        = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n    = LOAD_K;
          nest_clear = 1'b1;
          kbeat_n    = '0;
          kch_n      = '0;
          ibeat_n    = '0;
          irow_n     = '0;
          phase_n    = '0;
        end
      end

      LOAD_K: begin
        bus.con_ready      = 1'b1;
        beat               = bus.con_valid;
        ctrl_kds_le_select = KSEL_ONE << kbeat;
        ctrl_kds_ch_select = kch;
        if (beat) begin
          if (kbeat == KBEAT_LAST) begin
            kbeat_n = '0;
            if (kch == kch_last) begin
              kch_n   = '0;
              irow_n  = '0;
              ibeat_n = '0;
              state_n = LOAD_I;
            end else begin
              kch_n = kch + 1'b1;
            end
          end else begin
            kbeat_n = kbeat + 1'b1;
          end
        end
      end

      LOAD_I: begin
        bus.con_ready       = 1'b1;
        beat                = bus.con_valid;
        ctrl_idss_le_select = ibeat;
        if (beat) begin
          if (ibeat == IBEAT_LAST) begin
            ibeat_n = '0;
            state_n = I_SHIFT;
          end else begin
            ibeat_n = ibeat + 1'b1;
          end
        end
      end

      I_SHIFT: begin
        ctrl_idss_shift = 1'b1;
        if (irow == IROW_LAST) begin
          irow_n  = '0;
          phase_n = '0;
          state_n = COMPUTE;
        end else begin
          irow_n  = irow + 1'b1;
          state_n = LOAD_I;
        end
      end

      COMPUTE: begin
        ctrl_ods_sel_out = SELW'(32'(phase) % ODS_WAYS);
        driving_cons     = (32'(phase) >= 32'(COMPUTE_CYCLES - ODS_WAYS));
        if (32'(phase) < 32'(I_BEATS)) begin
          bus.con_ready       = 1'b1;
          beat                = bus.con_valid;
          ctrl_idss_le_select = IBW'(phase);
          phase_adv           = beat;
        end else begin
          phase_adv = 1'b1;
        end
        if (phase_adv) begin
          if (phase == PHASE_LAST) begin
            ctrl_idss_shift = 1'b1;
            ctrl_ods_shift  = 1'b1;
            load_out        = 1'b1;
            phase_n         = '0;
            state_n         = OUT_WAIT;
          end else begin
            phase_n = phase + 1'b1;
          end
        end
      end

      OUT_WAIT: begin
        if (bus.out_ready) begin
          nest_step = 1'b1;
          phase_n   = '0;
          if (!last_x) begin
            state_n = COMPUTE;
          end else if (!last_y) begin
            state_n = LOAD_I;
          end else if (last_overall) begin
            state_n = DONE;
          end else begin
            state_n = LOAD_K;
          end
        end
      end

      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Result register: captured at the last compute phase, held until accepted.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      bus.output_valid <= 1'b0;
      bus.output_x     <= '0;
      bus.output_y     <= '0;
      bus.output_ch    <= '0;
    end else if (load_out) begin
      bus.output_valid <= 1'b1;
      bus.output_x     <= 32'(x_cnt);
      bus.output_y     <= 32'(y_cnt);
      bus.output_ch    <= 32'(group_cnt) * 32'(CH_OUT_PAR);
    end else if (state == OUT_WAIT && bus.out_ready) begin
      bus.output_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_ctrl_fsm_gen.sv
// Scoreboard bench for conv_ctrl_fsm_gen: two instances (12 and 8 channels).
module tb_conv_ctrl_fsm_gen;

  typedef struct packed {
    logic        is_done;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] ch;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, start_a, start_b;
  logic con_valid_a, out_ready_a, valid_toggle;

  int checks = 0;
  int errors = 0;

  exp_t qa[$];
  exp_t qb[$];
  int   kqa[$];
  int   kqb[$];

  int         kcount[2];
  logic [11:0] prev_le[2];
  bit         prev_ink[2];
  bit         prev_cons[2];

  conv_ctrl_fsm_gen_if a_bus();
  conv_ctrl_fsm_gen_if b_bus();

  assign a_bus.con_valid = con_valid_a;
  assign a_bus.out_ready = out_ready_a;
  assign b_bus.con_valid = 1'b1;
  assign b_bus.out_ready = 1'b1;

  logic        a_running, a_done, a_ishift, a_oshift, a_drv;
  logic [11:0] a_kle;
  logic [2:0]  a_kch;
  logic [1:0]  a_isel, a_osel;
  logic        b_running, b_done, b_ishift, b_oshift, b_drv;
  logic [11:0] b_kle;
  logic [2:0]  b_kch;
  logic [1:0]  b_isel, b_osel;

  conv_ctrl_fsm_gen #(
    .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(12),
    .CH_OUT_PAR(6), .K_BEATS(12), .I_BEATS(4), .PRELOAD_ROWS(3),
    .COMPUTE_CYCLES(6), .ODS_WAYS(3)
  ) dut_a (
    .clk(clk), .rst_in(rst_a), .start(start_a), .running(a_running), .done(a_done),
    .bus(a_bus), .ctrl_kds_le_select(a_kle), .ctrl_kds_ch_select(a_kch),
    .ctrl_idss_le_select(a_isel), .ctrl_idss_shift(a_ishift), .ctrl_ods_shift(a_oshift),
    .ctrl_ods_sel_out(a_osel), .driving_cons(a_drv)
  );

  conv_ctrl_fsm_gen #(
    .FEATURE_MAP_WIDTH(2), .FEATURE_MAP_HEIGHT(2), .OUTPUT_NB_CHANNELS(8),
    .CH_OUT_PAR(6), .K_BEATS(12), .I_BEATS(4), .PRELOAD_ROWS(3),
    .COMPUTE_CYCLES(6), .ODS_WAYS(3)
  ) dut_b (
    .clk(clk), .rst_in(rst_b), .start(start_b), .running(b_running), .done(b_done),
    .bus(b_bus), .ctrl_kds_le_select(b_kle), .ctrl_kds_ch_select(b_kch),
    .ctrl_idss_le_select(b_isel), .ctrl_idss_shift(b_ishift), .ctrl_ods_shift(b_oshift),
    .ctrl_ods_sel_out(b_osel), .driving_cons(b_drv)
  );

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Pop the next expected item of instance d and compare with what the DUT shows.
  task automatic scoreItem(input int d, input exp_t got);
    exp_t want;
    if ((d == 0 && qa.size() == 0) || (d == 1 && qb.size() == 0)) begin
      checks++;
      errors++;
      $display("[TB] FAIL unexpected_item_%0d: actual=%h required=none", d, got);
    end else begin
      if (d == 0) want = qa.pop_front();
      else want = qb.pop_front();
      checkOutput(d == 0 ? "result_a" : "result_b", 128'(got), 128'(want));
    end
  endtask

  // Kernel-load beat checks: one-hot position, channel slot, hold on stall, group size.
  task automatic kernelMon(input int d, input logic [11:0] le, input logic [2:0] ch,
                           input bit cons);
    logic [11:0] one;
    bit ink;
    int want;
    one = 12'h001;
    ink = (le != 12'h000);
    if (ink && prev_ink[d] && !prev_cons[d])
      checkOutput("kds_hold", 128'(le), 128'(prev_le[d]));
    if (ink && cons) begin
      checkOutput("kds_le", 128'(le), 128'(one << (kcount[d] % 12)));
      checkOutput("kds_ch", 128'(ch), 128'(kcount[d] / 12));
      kcount[d]++;
    end
    if (!ink && prev_ink[d]) begin
      want = -1;
      if (d == 0 && kqa.size() > 0) want = kqa.pop_front();
      if (d == 1 && kqb.size() > 0) want = kqb.pop_front();
      checkOutput("kgroup_beats", 128'(kcount[d]), 128'(want));
      kcount[d] = 0;
    end
    prev_le[d]   = le;
    prev_ink[d]  = ink;
    prev_cons[d] = cons;
  endtask

  // Expected results of one full layer (W=H=2, 6 channels per group).
  task automatic pushLayer(input int d, input int nch);
    exp_t item;
    int ng;
    int beats;
    ng = (nch + 5) / 6;
    for (int g = 0; g < ng; g++) begin
      for (int y = 0; y < 2; y++) begin
        for (int x = 0; x < 2; x++) begin
          item = {1'b0, 32'(x), 32'(y), 32'(g * 6)};
          if (d == 0) qa.push_back(item);
          else qb.push_back(item);
        end
      end
      beats = ((g == ng - 1 && (nch % 6) != 0) ? (nch % 6) : 6) * 12;
      if (d == 0) kqa.push_back(beats);
      else kqb.push_back(beats);
    end
    item = {1'b1, 96'd0};
    if (d == 0) qa.push_back(item);
    else qb.push_back(item);
  endtask

  task automatic applyStimulus(input int d);
    @(posedge clk);
    #1;
    if (d == 0) start_a = 1'b1;
    else start_b = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic waitIdle(input int d, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((d == 0 ? a_running : b_running) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 128'(d == 0 ? a_running : b_running), 128'(0));
  endtask

  // Monitor for instance A: results, done pulses and kernel beats.
  always @(negedge clk) begin
    if (a_bus.output_valid && a_bus.out_ready)
      scoreItem(0, {1'b0, a_bus.output_x, a_bus.output_y, a_bus.output_ch});
    if (a_done) scoreItem(0, {1'b1, 96'd0});
    kernelMon(0, a_kle, a_kch, a_bus.con_ready && a_bus.con_valid);
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (b_bus.output_valid && b_bus.out_ready)
      scoreItem(1, {1'b0, b_bus.output_x, b_bus.output_y, b_bus.output_ch});
    if (b_done) scoreItem(1, {1'b1, 96'd0});
    kernelMon(1, b_kle, b_kch, b_bus.con_ready && b_bus.con_valid);
  end

  // Host valid driver: steady high, or toggling every cycle.
  initial begin
    con_valid_a = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      con_valid_a = valid_toggle ? ~con_valid_a : 1'b1;
    end
  end

  initial begin
    int n;
    rst_a = 1'b1; rst_b = 1'b1; start_a = 1'b0; start_b = 1'b0;
    out_ready_a = 1'b1; valid_toggle = 1'b0;
    for (int i = 0; i < 2; i++) begin
      kcount[i] = 0; prev_le[i] = '0; prev_ink[i] = 1'b0; prev_cons[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;
    rst_b = 1'b0;

    @(negedge clk);
    checkOutput("reset_running", 128'(a_running), 128'(0));
    checkOutput("reset_done", 128'(a_done), 128'(0));
    checkOutput("reset_con_ready", 128'(a_bus.con_ready), 128'(0));
    checkOutput("reset_output_valid", 128'(a_bus.output_valid), 128'(0));
    checkOutput("reset_coords", {32'd0, a_bus.output_x, a_bus.output_y, a_bus.output_ch}, 128'(0));
    checkOutput("reset_kds", {a_kle, a_kch}, 128'(0));
    checkOutput("reset_idss", {a_isel, a_ishift, a_oshift, a_drv}, 128'(0));
    checkOutput("reset_ods_sel", 128'(a_osel), 128'(3));
    checkOutput("reset_b_outputs", {b_running, b_done, b_kle, b_kch, b_isel, b_ishift,
                                    b_oshift, b_drv, b_bus.output_valid}, 128'(0));
    checkOutput("reset_b_ods_sel", 128'(b_osel), 128'(3));

    $display("[TB] default layer, 12 channels");
    pushLayer(0, 12);
    applyStimulus(0);
    waitIdle(0, "default_finish");
    checkOutput("default_results_left", 128'(qa.size()), 128'(0));
    checkOutput("default_kgroups_left", 128'(kqa.size()), 128'(0));

    $display("[TB] host valid toggling");
    valid_toggle = 1'b1;
    pushLayer(0, 12);
    applyStimulus(0);
    waitIdle(0, "toggle_finish");
    valid_toggle = 1'b0;
    checkOutput("toggle_results_left", 128'(qa.size()), 128'(0));

    $display("[TB] result back-pressure");
    out_ready_a = 1'b0;
    pushLayer(0, 12);
    applyStimulus(0);
    n = 0;
    @(negedge clk);
    while (!a_bus.output_valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("stall_reach_valid", 128'(a_bus.output_valid), 128'(1));
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("stall_hold", {a_bus.output_valid, a_bus.output_x, a_bus.output_y,
                                 a_bus.output_ch}, {1'b1, 96'd0});
    end
    @(posedge clk);
    #1;
    out_ready_a = 1'b1;
    @(negedge clk);
    checkOutput("stall_valid_6th", 128'(a_bus.output_valid), 128'(1));
    @(negedge clk);
    checkOutput("stall_valid_drop", 128'(a_bus.output_valid), 128'(0));
    waitIdle(0, "stall_finish");
    checkOutput("stall_results_left", 128'(qa.size()), 128'(0));

    $display("[TB] reset during compute");
    kqa.push_back(72);
    applyStimulus(0);
    n = 0;
    @(negedge clk);
    while (!a_drv && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("abort_reach_phase3", 128'(a_drv), 128'(1));
    rst_a = 1'b1;
    @(negedge clk);
    checkOutput("abort_running", 128'(a_running), 128'(0));
    checkOutput("abort_output_valid", 128'(a_bus.output_valid), 128'(0));
    checkOutput("abort_ods_sel", 128'(a_osel), 128'(3));
    checkOutput("abort_done", 128'(a_done), 128'(0));
    rst_a = 1'b0;
    pushLayer(0, 12);
    applyStimulus(0);
    waitIdle(0, "restart_finish");
    checkOutput("restart_results_left", 128'(qa.size()), 128'(0));
    checkOutput("restart_kgroups_left", 128'(kqa.size()), 128'(0));

    $display("[TB] partial group, start held through done");
    pushLayer(1, 8);
    pushLayer(1, 8);
    @(posedge clk);
    #1;
    start_b = 1'b1;
    n = 0;
    @(negedge clk);
    while (!b_done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checkOutput("held_reach_done", 128'(b_done), 128'(1));
    @(negedge clk);
    checkOutput("held_idle_after_done", {b_running, b_done}, 128'(0));
    @(negedge clk);
    checkOutput("held_restart", 128'(b_running), 128'(1));
    @(posedge clk);
    #1;
    start_b = 1'b0;
    waitIdle(1, "held_finish");
    checkOutput("held_results_left", 128'(qb.size()), 128'(0));
    checkOutput("held_kgroups_left", 128'(kqb.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
